sru_dtc_cmd_tx: RTL and testbench

SRU_DTC_CMD_TX -- requirements
Module: sru_dtc_cmd_tx

---
 rtl/sru_dtc_cmd_tx.sv | 249 ++++++++++++++++++++++++
 tb/tb_sru_dtc_cmd_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sru_dtc_cmd_tx.sv
// Serial trigger/command transmitter towards a slave DTC, with reply timing.
// Optional macro DTC_TX_PARITY_EN appends an odd-parity bit to every frame.
module sru_dtc_cmd_tx #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 2
) (
    input  logic        rdoclk,
    input  logic        reset,
    input  logic        trig_l0,
    input  logic        trig_l1,
    input  logic        rdo_req,
    input  logic        abort_req,
    input  logic        sync_req,
    input  logic        rst_req,
    input  logic        cmd_exec,
    input  logic        cmd_rnw,
    input  logic        cmd_feenal,
    input  logic [19:0] cmd_addr,
    input  logic [19:0] cmd_wdata,
    input  logic        dtc_return,
    output logic        dtc_trig,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_timeout,
    output logic        trig_drop
);

`ifdef DTC_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam logic [5:0]  SHORT_LEN = 6'(5 + PAR);
    localparam logic [5:0]  LONG_LEN  = 6'(47 + PAR);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 2);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t      state, state_n;
    logic [47:0] sr, sr_n;
    logic [5:0]  left, left_n;
    logic [7:0]  gap, gap_n;
    logic        is_cmd, is_cmd_n;
    logic        trig_n;
    logic        take;
    logic        frame_end;

    // pending order: 0 L0, 1 L1, 2 RST, 3 ABORT, 4 RDO, 5 SYNC, 6 CMD
    logic [6:0]  pend;
    logic [6:0]  req;
    logic [6:0]  sel;
    logic [6:0]  clr;
    logic        cmd_acc;

    logic        rnw_q, fee_q;
    logic [19:0] addr_q, wdata_q;

    logic [3:0]  code;
    logic [46:0] body;
    logic        par;
    logic [47:0] frame;
    logic [5:0]  len;

    logic [15:0] tmr;
    logic        run;
    logic        s1, s2, s3;
    logic        reply_edge;

    assign cmd_acc    = cmd_exec & ~cmd_busy;
    assign req        = {cmd_acc, sync_req, rdo_req, abort_req,
                         rst_req, trig_l1, trig_l0};
    assign clr        = take ? sel : 7'd0;
    assign reply_edge = s2 & ~s3;

    // Priority pick of the next frame and its MSB-aligned bit image
    always_comb begin
        sel  = '0;
        code = '0;
        if (pend[0]) begin
            sel[0] = 1'b1; code = 4'd1;
        end else if (pend[1]) begin
            sel[1] = 1'b1; code = 4'd2;
        end else if (pend[2]) begin
            sel[2] = 1'b1; code = 4'd6;
        end else if (pend[3]) begin
            sel[3] = 1'b1; code = 4'd4;
        end else if (pend[4]) begin
            sel[4] = 1'b1; code = 4'd3;
        end else if (pend[5]) begin
            sel[5] = 1'b1; code = 4'd5;
        end else if (pend[6]) begin
            sel[6] = 1'b1; code = 4'd8;
        end
        body = {1'b1, 4'd8, rnw_q, fee_q, addr_q, wdata_q};
        if (sel[6]) begin
            par   = (PAR != 0) ? ~^body : 1'b0;
            frame = {body, par};
            len   = LONG_LEN;
        end else begin
            par   = (PAR != 0) ? ~^{1'b1, code} : 1'b0;
            frame = {1'b1, code, par, 42'd0};
            len   = SHORT_LEN;
        end
    end

    // Frame FSM: next state, shift register and serial line
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        left_n    = left;
        gap_n     = gap;
        is_cmd_n  = is_cmd;
        trig_n    = 1'b0;
        take      = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|pend) begin
                    take     = 1'b1;
                    trig_n   = frame[47];
                    sr_n     = {frame[46:0], 1'b0};
                    left_n   = len - 6'd1;
                    is_cmd_n = sel[6];
                    state_n  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (left != 6'd0) begin
                    trig_n = sr[47];
                    sr_n   = {sr[46:0], 1'b0};
                    left_n = left - 6'd1;
                end else begin
                    frame_end = is_cmd;
                    gap_n     = 8'd0;
                    state_n   = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap == GAP_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    gap_n = gap + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM and shifter registers; reset cuts a frame off immediately
    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sr       <= '0;
            left     <= '0;
            gap      <= '0;
            is_cmd   <= 1'b0;
            dtc_trig <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            left     <= left_n;
            gap      <= gap_n;
            is_cmd   <= is_cmd_n;
            dtc_trig <= trig_n;
        end
    end

    // Request flags; a repeat while still pending is lost
    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            pend      <= '0;
            trig_drop <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | req;
            if (|(req[1:0] & pend[1:0] & ~clr[1:0])) begin
                trig_drop <= 1'b1;
            end
        end
    end

    // Command fields are frozen at acceptance
    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            rnw_q   <= 1'b0;
            fee_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cmd_acc) begin
            rnw_q   <= cmd_rnw;
            fee_q   <= cmd_feenal;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // Two-flop synchronizer plus edge-detect stage for the reply line
    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= dtc_return;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Reply timer: timeout pulse shows in the cycle the count hits TIMEOUT_CYC-1
    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            tmr         <= '0;
            run         <= 1'b0;
            cmd_busy    <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_timeout <= 1'b0;
        end else begin
            cmd_done    <= 1'b0;
            cmd_timeout <= 1'b0;
            if (cmd_acc) begin
                cmd_busy <= 1'b1;
            end
            if (frame_end) begin
                run <= 1'b1;
                tmr <= '0;
            end else if (run) begin
                if (reply_edge) begin
                    cmd_done <= 1'b1;
                    cmd_busy <= 1'b0;
                    run      <= 1'b0;
                end else if (tmr == TMO_LAST) begin
                    cmd_timeout <= 1'b1;
                    cmd_busy    <= 1'b0;
                    run         <= 1'b0;
                    tmr         <= tmr + 16'd1;
                end else begin
                    tmr <= tmr + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sru_dtc_cmd_tx.sv
// Directed bench for sru_dtc_cmd_tx: frame images, ordering, drop, reply timing.
// Follows DTC_TX_PARITY_EN so frame lengths match the build under test.
module tb_sru_dtc_cmd_tx;

`ifdef DTC_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int GAP   = 2;
    localparam int SHORT = 5 + PB;
    localparam int LONG  = 47 + PB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig_l0 = 0, trig_l1 = 0, rdo_req = 0, abort_req = 0;
    logic        sync_req = 0, rst_req = 0, cmd_exec = 0;
    logic        cmd_rnw = 0, cmd_feenal = 0;
    logic [19:0] cmd_addr = '0, cmd_wdata = '0;
    logic        dtc_return = 0;

    logic dtc_trig, cmd_busy, cmd_done, cmd_timeout, trig_drop;
    logic t64_trig, t64_busy, t64_done, t64_tmo, t64_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sru_dtc_cmd_tx #(.TIMEOUT_CYC(4096), .GAP_CYC(GAP)) u_dut (
        .rdoclk(clk), .reset(reset),
        .trig_l0(trig_l0), .trig_l1(trig_l1),
        .rdo_req(rdo_req), .abort_req(abort_req),
        .sync_req(sync_req), .rst_req(rst_req),
        .cmd_exec(cmd_exec), .cmd_rnw(cmd_rnw), .cmd_feenal(cmd_feenal),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .dtc_return(dtc_return), .dtc_trig(dtc_trig),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done),
        .cmd_timeout(cmd_timeout), .trig_drop(trig_drop)
    );

    sru_dtc_cmd_tx #(.TIMEOUT_CYC(64), .GAP_CYC(GAP)) u_dut64 (
        .rdoclk(clk), .reset(reset),
        .trig_l0(trig_l0), .trig_l1(trig_l1),
        .rdo_req(rdo_req), .abort_req(abort_req),
        .sync_req(sync_req), .rst_req(rst_req),
        .cmd_exec(cmd_exec), .cmd_rnw(cmd_rnw), .cmd_feenal(cmd_feenal),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .dtc_return(dtc_return), .dtc_trig(t64_trig),
        .cmd_busy(t64_busy), .cmd_done(t64_done),
        .cmd_timeout(t64_tmo), .trig_drop(t64_drop)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // r = {cmd_exec, sync, rdo, abort, rst, l1, l0}
    task automatic drive(input logic [6:0] r);
        trig_l0   = r[0];
        trig_l1   = r[1];
        rst_req   = r[2];
        abort_req = r[3];
        rdo_req   = r[4];
        sync_req  = r[5];
        cmd_exec  = r[6];
    endtask

    task automatic pulse(input logic [6:0] r);
        drive(r);
        tick();
        drive(7'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [47:0] short_exp(input logic [3:0] code);
        logic [4:0] b;
        b = {1'b1, code};
        if (PB != 0) return {42'd0, b, ~^b};
        return {43'd0, b};
    endfunction

    function automatic logic [47:0] long_exp();
        logic [46:0] b;
        b = {1'b1, 4'd8, cmd_rnw, cmd_feenal, cmd_addr, cmd_wdata};
        if (PB != 0) return {b, ~^b};
        return {1'b0, b};
    endfunction

    // Wait for a start bit, then collect n bits; hooks pulse requests mid-frame
    task automatic get_frame(input string tag, input int n,
                             input int h1, input int h2,
                             input logic [6:0] hr,
                             output logic [47:0] v, output int gap);
        v   = '0;
        gap = 0;
        tick();
        while (dtc_trig !== 1'b1 && gap < 60) begin
            gap++;
            tick();
        end
        if (gap >= 60) begin
            check({tag, "_start"}, 64'd0, 64'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                v = {v[46:0], dtc_trig};
                if (i == n - 1) break;
                if (i == h1 || i == h2) drive(hr);
                tick();
                drive(7'd0);
            end
        end
    endtask

    logic [47:0] v;
    int          gap;
    int          hit;
    logic        any;

    initial begin
        // reset state
        tick();
        check("rst_trig", {63'd0, dtc_trig}, 64'd0);
        check("rst_busy", {63'd0, cmd_busy}, 64'd0);
        check("rst_drop", {63'd0, trig_drop}, 64'd0);
        check("rst_done", {63'd0, cmd_done | cmd_timeout}, 64'd0);
        reset = 1'b0;
        tick();

        // single L0 frame followed by a low gap
        pulse(7'b0000001);
        get_frame("l0", SHORT, -1, -1, 7'd0, v, gap);
        check("l0_frame", {16'd0, v}, {16'd0, short_exp(4'd1)});
        for (int i = 0; i < GAP; i++) begin
            tick();
            check("l0_gap", {63'd0, dtc_trig}, 64'd0);
        end

        // command with reply 100 cycles after the last bit
        cmd_rnw = 1; cmd_feenal = 0;
        cmd_addr = 20'h00012; cmd_wdata = 20'h0;
        pulse(7'b1000000);
        check("cmd_busy_set", {63'd0, cmd_busy}, 64'd1);
        get_frame("cmd1", LONG, -1, -1, 7'd0, v, gap);
        check("cmd1_frame", {16'd0, v}, {16'd0, long_exp()});
        any = 1'b0;
        for (int k = 0; k < 99; k++) begin
            if (k == 10) begin
                cmd_addr = 20'hFFFFF;
                drive(7'b1000000);
            end
            tick();
            drive(7'd0);
            any = any | dtc_trig | cmd_done | cmd_timeout;
        end
        check("busy_ignore", {63'd0, any}, 64'd0);
        check("busy_hold", {63'd0, cmd_busy}, 64'd1);
        tick();
        dtc_return = 1'b1;
        hit = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (cmd_done === 1'b1 && hit == 0) hit = k;
        end
        check("done_lat", 64'(hit), 64'd3);
        check("done_busy", {63'd0, cmd_busy}, 64'd0);
        tick();
        check("done_pulse", {63'd0, cmd_done}, 64'd0);
        dtc_return = 1'b0;

        // no reply: the 64-cycle instance times out
        do_reset();
        cmd_rnw = 0; cmd_feenal = 1;
        cmd_addr = 20'h5A5A5; cmd_wdata = 20'h3C3C3;
        pulse(7'b1000000);
        get_frame("cmd2", LONG, -1, -1, 7'd0, v, gap);
        check("cmd2_frame", {16'd0, v}, {16'd0, long_exp()});
        hit = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (t64_tmo === 1'b1 && hit == 0) hit = k;
            if (t64_done === 1'b1) hit = -1;
        end
        check("tmo_lat", 64'(hit), 64'd64);
        check("tmo_busy", {63'd0, t64_busy}, 64'd0);

        // L1 raised mid-CMD waits for the frame plus gap
        do_reset();
        cmd_rnw = 1; cmd_feenal = 1;
        cmd_addr = 20'hABCDE; cmd_wdata = 20'h13579;
        pulse(7'b1000000);
        get_frame("cmd3", LONG, 10, -1, 7'b0000010, v, gap);
        check("cmd3_frame", {16'd0, v}, {16'd0, long_exp()});
        get_frame("l1", SHORT, -1, -1, 7'd0, v, gap);
        check("l1_frame", {16'd0, v}, {16'd0, short_exp(4'd2)});
        check("l1_gap", {63'd0, gap >= GAP && gap <= GAP + 1}, 64'd1);
        check("l1_nodrop", {63'd0, trig_drop}, 64'd0);

        // two L0 pulses during one frame: one L0 frame, drop set
        do_reset();
        pulse(7'b1000000);
        get_frame("cmd4", LONG, 5, 15, 7'b0000001, v, gap);
        check("drop_set", {63'd0, trig_drop}, 64'd1);
        get_frame("l0b", SHORT, -1, -1, 7'd0, v, gap);
        check("l0b_frame", {16'd0, v}, {16'd0, short_exp(4'd1)});
        any = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            any = any | dtc_trig;
        end
        check("l0b_single", {63'd0, any}, 64'd0);
        check("drop_sticky", {63'd0, trig_drop}, 64'd1);
        do_reset();
        check("drop_clr", {63'd0, trig_drop}, 64'd0);

        // simultaneous L0, RST, CMD -> L0, RST, CMD order
        cmd_rnw = 0; cmd_feenal = 0;
        cmd_addr = 20'h00F0F; cmd_wdata = 20'hF0F0F;
        pulse(7'b1000101);
        get_frame("ord0", SHORT, -1, -1, 7'd0, v, gap);
        check("ord_l0", {16'd0, v}, {16'd0, short_exp(4'd1)});
        get_frame("ord1", SHORT, -1, -1, 7'd0, v, gap);
        check("ord_rst", {16'd0, v}, {16'd0, short_exp(4'd6)});
        get_frame("ord2", LONG, -1, -1, 7'd0, v, gap);
        check("ord_cmd", {16'd0, v}, {16'd0, long_exp()});

        // remaining special codes: ABORT > RDO > SYNC
        do_reset();
        pulse(7'b0111000);
        get_frame("sp0", SHORT, -1, -1, 7'd0, v, gap);
        check("sp_abort", {16'd0, v}, {16'd0, short_exp(4'd4)});
        get_frame("sp1", SHORT, -1, -1, 7'd0, v, gap);
        check("sp_rdo", {16'd0, v}, {16'd0, short_exp(4'd3)});
        get_frame("sp2", SHORT, -1, -1, 7'd0, v, gap);
        check("sp_sync", {16'd0, v}, {16'd0, short_exp(4'd5)});

        // reset at bit 20 of a CMD frame (addr[6]=1 puts a 1 there)
        do_reset();
        cmd_rnw = 0; cmd_feenal = 0;
        cmd_addr = 20'h00040; cmd_wdata = 20'h0;
        pulse(7'b1000000);
        get_frame("cut", 21, -1, -1, 7'd0, v, gap);
        check("cut_bit20", {63'd0, v[0]}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("cut_trig", {63'd0, dtc_trig}, 64'd0);
        check("cut_busy", {63'd0, cmd_busy}, 64'd0);
        tick();
        reset = 1'b0;
        any = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            any = any | dtc_trig | cmd_done | cmd_timeout
                      | t64_done | t64_tmo;
        end
        check("cut_quiet", {63'd0, any}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
